// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the load/store memory port.
// Contents: RV32I width codes, FSM state encoding, default memory depth.
package lsu_mem_port_pkg;

  // Default number of 32-bit words in the attached data memory.
  localparam int LSU_DEPTH_DEFAULT = 64;

  // RV32I load/store width codes (funct3).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_WR = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// Combinational byte/half lane steering shared by loads and sub-word stores.
// Ports:
//   i_word      32-bit memory word
//   i_off       byte offset within the word (addr[1:0])
//   i_funct3    RV32I width code
//   i_wdata     right-aligned store data
//   o_load_data selected lane, sign- or zero-extended
//   o_merged    i_word with the target lane replaced by i_wdata
module lsu_lane_align
  import lsu_mem_port_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection uses only the low address bits; no carry into the index.
  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

  // Load direction: extend the selected lane according to the width code.
  always_comb begin
    o_load_data = 32'h0000_0000;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h00_0000, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0000, w_half};
      F3_W:    o_load_data = i_word;
      default: o_load_data = 32'h0000_0000;
    endcase
  end

  // Store direction: overwrite only the addressed lane, keep the other bytes.
  always_comb begin
    o_merged = i_word;
    case (i_funct3)
      F3_B:    o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      F3_H:    o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      F3_W:    o_merged = i_wdata;
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator between the MEM stage and a word-addressed data memory.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   req_*                  byte-addressed RV32I load/store request handshake
//   resp_*                 one-cycle registered completion with data and flags
//   MemRead, MemWrite, A   memory enables and word index (combinational)
//   WD / RD                memory write data / combinational read data
// SW and loads complete in one cycle; SB/SH do read-modify-write over two.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int DEPTH = LSU_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] A,
  output logic [31:0] WD,
  input  logic [31:0] RD
);

  lsu_state_e  r_state;
  lsu_state_e  w_next_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [2:0]  r_funct3;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_mis;
  logic        r_resp_fault;

  logic        w_accept;
  logic        w_unsup;
  logic        w_oor;
  logic        w_mis;
  logic        w_ok;
  logic        w_is_rmw;
  logic        w_in_rmw;
  logic [31:0] w_align_word;
  logic [1:0]  w_align_off;
  logic [2:0]  w_align_f3;
  logic [31:0] w_align_wdata;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;
  logic        w_mem_read;
  logic        w_mem_write;
  logic [31:0] w_a;
  logic [31:0] w_wd;

  assign w_in_rmw  = (r_state == ST_RMW_WR);
  assign req_ready = !w_in_rmw;
  assign w_accept  = req_valid && req_ready;

  // Checks on the live request; priority is unsupported > range > alignment.
  assign w_unsup = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) ||
                   (req_we && (req_funct3 != F3_B) && (req_funct3 != F3_H) &&
                    (req_funct3 != F3_W));
  assign w_oor   = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign w_mis   = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                   ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  assign w_ok    = !w_unsup && !w_oor && !w_mis;
  assign w_is_rmw = req_we && (req_funct3 != F3_W);

  // One aligner: live request while idle, latched request during the RMW write.
  assign w_align_word  = w_in_rmw ? r_word         : RD;
  assign w_align_off   = w_in_rmw ? r_addr[1:0]    : req_addr[1:0];
  assign w_align_f3    = w_in_rmw ? r_funct3       : req_funct3;
  assign w_align_wdata = w_in_rmw ? r_wdata        : req_wdata;

  lsu_lane_align u_align (
    .i_word      (w_align_word),
    .i_off       (w_align_off),
    .i_funct3    (w_align_f3),
    .i_wdata     (w_align_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // Next state and memory-port drive.
  always_comb begin
    w_next_state = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_a          = 32'h0000_0000;
    w_wd         = 32'h0000_0000;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept && w_ok) begin
          w_a = {2'b00, req_addr[31:2]};
          if (req_we && !w_is_rmw) begin
            w_mem_write  = 1'b1;
            w_wd         = req_wdata;
            w_next_state = ST_IDLE;
          end else if (w_is_rmw) begin
            w_mem_read   = 1'b1;
            w_next_state = ST_RMW_WR;
          end else begin
            w_mem_read   = 1'b1;
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RMW_WR: begin
        w_mem_write  = 1'b1;
        w_a          = {2'b00, r_addr[31:2]};
        w_wd         = w_merged;
        w_next_state = ST_RESP;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Reset suppresses any memory access, including a pending RMW write.
  assign MemRead  = w_mem_read  && !reset;
  assign MemWrite = w_mem_write && !reset;
  assign A        = reset ? 32'h0000_0000 : w_a;
  assign WD       = reset ? 32'h0000_0000 : w_wd;

  // State, RMW latch and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= 32'h0000_0000;
      r_wdata      <= 32'h0000_0000;
      r_word       <= 32'h0000_0000;
      r_funct3     <= 3'b000;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_resp_mis   <= 1'b0;
      r_resp_fault <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_resp_mis   <= 1'b0;
      r_resp_fault <= 1'b0;
      if (w_in_rmw) begin
        r_resp_valid <= 1'b1;
      end else if (w_accept) begin
        if (w_unsup || w_oor) begin
          r_resp_valid <= 1'b1;
          r_resp_fault <= 1'b1;
        end else if (w_mis) begin
          r_resp_valid <= 1'b1;
          r_resp_mis   <= 1'b1;
        end else if (w_is_rmw) begin
          // Response for SB/SH is deferred until after the write cycle.
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_funct3 <= req_funct3;
          r_word   <= RD;
        end else begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= req_we ? 32'h0000_0000 : w_load_data;
        end
      end else begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign resp_valid      = r_resp_valid;
  assign resp_rdata      = r_resp_rdata;
  assign resp_misaligned = r_resp_mis;
  assign resp_fault      = r_resp_fault;

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator between the pipeline MEM stage and the word-addressed data memory.
- Accepts one byte-addressed RV32I load/store per handshake and translates the byte address to a word index.
- Loads: selects, then sign/zero-extends the addressed byte or half. Stores: SW is a single write; SB/SH are a two-cycle read-modify-write.
- Flags misaligned, out-of-range and unsupported accesses without touching memory.

Parameters:
- DEPTH, 64, number of 32-bit words in the data memory; a word index >= DEPTH is out of range.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faulted requests.
- resp_misaligned  out  1  valid with resp_valid.
- resp_fault  out  1  out-of-range or unsupported funct3; valid with resp_valid.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- A  out  32  word index = {2'b00, addr[31:2]}.
- WD  out  32  memory write data.
- RD  in  32  memory read data; combinational from A and MemRead.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - resp_valid, resp_misaligned, resp_fault, MemRead and MemWrite are 0.
  - resp_rdata, A and WD are 0.
  - req_ready is 1 from the first cycle after reset deasserts.
- States: IDLE, RMW_WR, RESP.
  - Memory-port outputs are combinational from state, the live request (IDLE) or the latched request (RMW_WR).
  - Response outputs are registered.
- IDLE:
  - req_ready = 1.
  - A request is accepted when req_valid && req_ready.
  - Request inputs must be stable only in the acceptance cycle.
- Access checks, in priority order:
  - Unsupported: funct3 in {011, 110, 111}, or a store with funct3 not in {000, 001, 010}.
  - Out of range: addr[31:2] >= DEPTH.
  - Misaligned: H access with addr[0] = 1, or W access with addr[1:0] != 0.
  - Any failing check means MemRead = MemWrite = 0.
  - The next cycle gives a resp_valid pulse with the matching flag and resp_rdata = 0; state stays IDLE.
  - The misaligned flag is reported only when the fault checks pass.
- Load (latency 1):
  - Acceptance cycle: MemRead = 1 and A = index.
  - On that edge, capture the extracted lane from RD: byte RD[8*addr[1:0] +: 8], half RD[16*addr[1] +: 16].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Next cycle: resp_valid = 1 with the data. State stays IDLE, so back-to-back requests are allowed.
- SW (latency 1):
  - Acceptance cycle: MemWrite = 1, WD = req_wdata.
  - Next cycle: resp_valid = 1, resp_rdata = 0.
- SB/SH read-modify-write (latency 2):
  - Acceptance cycle: MemRead = 1. RD is latched into the merge register, together with addr, funct3 and wdata; go to RMW_WR.
  - RMW_WR: req_ready = 0, MemWrite = 1, MemRead = 0, A = latched index.
  - WD = latched word with the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH); other bytes unchanged.
  - Then go to RESP.
  - RESP: resp_valid = 1, req_ready = 1; a new request is accepted in this cycle.
- resp_valid is high for exactly one cycle per accepted request. Responses are returned in order, and at most one request is outstanding.
- Reset mid-operation: reset in the acceptance cycle or in RMW_WR means no write is issued on the following cycle and no response is produced. A reset coincident with the RMW_WR write has priority in memory, which clears anyway.
- Arithmetic: all lane selection uses addr[1:0] only; no carries; no wrap of the index. Out-of-range requests fault rather than alias.

Decomposition:
- Shared package:
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State encoding.
  - DEPTH default.
- One natural sub-module: lsu_lane_align (combinational).
  - Load direction: word + offset + funct3 -> extended data.
  - Store direction: word + offset + funct3 + wdata -> merged word.
  - Shared by load extraction and RMW merge.

Test Plan:
- Preload word 5 = 0x8899AABB. LB at addr 0x15 -> resp_rdata 0xFFFFFFAA, 1 cycle after accept. LBU at the same addr -> 0x000000AA. LHU at 0x16 -> 0x00008899.
- Word 3 = 0x11223344. SB addr 0x0D, wdata 0x000000EE: MemRead in the accept cycle, MemWrite with WD = 0x1122EE44 next cycle, resp_valid the cycle after. A later LW at 0x0C -> 0x1122EE44.
- SW addr 0x20, wdata 0xDEADBEEF: MemWrite in the accept cycle, A = 8. LW issued in the RESP/idle cycle back-to-back -> 0xDEADBEEF.
- LH addr 0x03 -> resp_misaligned = 1, resp_rdata = 0, no MemRead/MemWrite. SW addr 0x100 (index 64) -> resp_fault = 1, no MemWrite. funct3 011 -> resp_fault = 1.
- Assert reset during RMW_WR of an SH -> MemWrite is 0 the next cycle, no resp_valid, req_ready = 1 afterward.
- Hold req_valid high with 4 back-to-back SH requests -> req_ready drops for exactly one cycle each. Four resp_valid pulses arrive in order, and final memory contents match the merged values.
